// File: rtl/flap_controller.sv
// Flap pushbutton conditioning (synchronize, debounce, one-shot, cooldown)
// and the top-level game FSM that drives the bird physics block.
module flap_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic collision,
    output logic enable,
    output logic restart,
    output logic flap,
    output logic game_over
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, DEAD, RSTRT} state_t;

    logic          sync1_reg, sync2_reg;
    logic          key_s;
    logic          key_db_reg, key_db_next, key_db_d_reg;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] cool_reg, cool_next;
    logic          press;
    state_t        state_reg, state_next;
    logic          enable_reg, restart_reg, flap_reg, game_over_reg;
    logic          flap_next;

    assign key_s = ~sync2_reg;
    assign press = key_db_reg & ~key_db_d_reg;

    // Counter only runs while the synchronized key disagrees with the debounced one
    always_comb begin
        key_db_next = key_db_reg;
        cnt_next    = '0;
        if (key_s != key_db_reg) begin
            if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_db_next = key_s;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        flap_next  = 1'b0;
        cool_next  = (cool_reg != '0) ? cool_reg - 1'b1 : '0;
        case (state_reg)
            IDLE: begin
                if (press) state_next = PLAY;
            end
            PLAY: begin
                // Collision wins over a same-cycle press
                if (collision) begin
                    state_next = DEAD;
                end else if (press && cool_reg == '0) begin
                    flap_next = 1'b1;
                    cool_next = CW'(COOLDOWN_CYCLES);
                end
            end
            DEAD: begin
                if (!collision && press) state_next = RSTRT;
            end
            RSTRT: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            key_db_reg    <= 1'b0;
            key_db_d_reg  <= 1'b0;
            cnt_reg       <= '0;
            cool_reg      <= '0;
            state_reg     <= IDLE;
            enable_reg    <= 1'b0;
            restart_reg   <= 1'b0;
            flap_reg      <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            sync1_reg     <= key_n;
            sync2_reg     <= sync1_reg;
            key_db_reg    <= key_db_next;
            key_db_d_reg  <= key_db_reg;
            cnt_reg       <= cnt_next;
            cool_reg      <= cool_next;
            state_reg     <= state_next;
            enable_reg    <= (state_next == PLAY);
            restart_reg   <= (state_next == RSTRT);
            flap_reg      <= flap_next;
            game_over_reg <= (state_next == DEAD);
        end
    end

    assign enable    = enable_reg;
    assign restart   = restart_reg;
    assign flap      = flap_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_flap_controller.sv
// Directed self-checking bench for flap_controller: default instance plus a
// DEBOUNCE_CYCLES=1 instance used to exercise the flap cooldown.
module tb_flap_controller;

    logic clk = 1'b0;
    logic rst;
    logic key_n, collision;
    logic enable, restart, flap, game_over;
    logic key_n2, collision2;
    logic enable2, restart2, flap2, game_over2;

    int checks = 0;
    int failures = 0;
    int cnt;

    always #5 clk = ~clk;

    flap_controller dut (
        .clk(clk), .reset(rst), .key_n(key_n), .collision(collision),
        .enable(enable), .restart(restart), .flap(flap), .game_over(game_over)
    );

    flap_controller #(.DEBOUNCE_CYCLES(1), .COOLDOWN_CYCLES(3)) dut2 (
        .clk(clk), .reset(rst), .key_n(key_n2), .collision(collision2),
        .enable(enable2), .restart(restart2), .flap(flap2), .game_over(game_over2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    // Lands 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; collision = 1'b0; key_n2 = 1'b1; collision2 = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("reset_enable", enable, 0);
        check("reset_flap", flap, 0);
        check("reset_restart", restart, 0);
        check("reset_game_over", game_over, 0);

        // Start press: enable rises at edge 7, no flap
        key_n = 1'b0;
        tick(6);
        check("start_enable_e6", enable, 0);
        tick(1);
        check("start_enable_e7", enable, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (flap) cnt++;
            tick(1);
        end
        check("start_no_flap", cnt, 0);
        key_n = 1'b1;
        tick(10);

        // Second press flaps exactly once at edge 7
        key_n = 1'b0;
        tick(6);
        check("flap_e6", flap, 0);
        tick(1);
        check("flap_e7", flap, 1);
        tick(1);
        check("flap_e8", flap, 0);
        key_n = 1'b1;
        tick(10);

        // 3-cycle glitch is filtered
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (flap) cnt++;
        end
        check("glitch_no_flap", cnt, 0);
        check("glitch_enable", enable, 1);

        // Collision in the same cycle as a debounced press
        key_n = 1'b0;
        tick(6);
        collision = 1'b1;
        tick(1);
        check("coll_flap", flap, 0);
        check("coll_enable", enable, 0);
        check("coll_game_over", game_over, 1);
        key_n = 1'b1;
        tick(10);
        key_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (restart) cnt++;
        end
        check("dead_press_ignored_restart", cnt, 0);
        check("dead_press_ignored_go", game_over, 1);
        key_n = 1'b1;
        tick(10);
        collision = 1'b0;
        tick(2);
        key_n = 1'b0;
        tick(6);
        check("restart_e6", restart, 0);
        tick(1);
        check("restart_e7", restart, 1);
        check("restart_game_over", game_over, 0);
        check("restart_enable", enable, 0);
        tick(1);
        check("restart_e8", restart, 0);
        check("idle_after_restart_enable", enable, 0);
        key_n = 1'b1;
        tick(10);

        // Re-enter PLAY, then async reset mid-cycle
        key_n = 1'b0;
        tick(7);
        check("replay_enable", enable, 1);
        key_n = 1'b1;
        tick(10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_enable", enable, 0);
        check("async_rst_flap", flap, 0);
        check("async_rst_game_over", game_over, 0);
        tick(2);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (restart || enable) cnt++;
        end
        check("post_rst_idle", cnt, 0);

        // Cooldown on the DEBOUNCE_CYCLES=1 instance
        key_n2 = 1'b0;
        tick(3);
        check("cd_enable_e3", enable2, 0);
        tick(1);
        check("cd_enable_e4", enable2, 1);
        key_n2 = 1'b1;
        tick(6);
        key_n2 = 1'b0;
        tick(1);
        key_n2 = 1'b1;
        tick(1);
        key_n2 = 1'b0;
        tick(1);
        tick(1);
        check("cd_first_flap", flap2, 1);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (flap2) cnt++;
        end
        check("cd_second_dropped", cnt, 0);
        key_n2 = 1'b1;
        tick(6);
        key_n2 = 1'b0;
        tick(3);
        check("cd_third_e3", flap2, 0);
        tick(1);
        check("cd_third_flap", flap2, 1);
        tick(1);
        check("cd_third_single", flap2, 0);
        key_n2 = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
